logit_argmax: RTL
=================

Name: logit_argmax

Overview:
- Streaming stage directly downstream of the inference datapath.
- Consumes the output-layer logits, one FP16 value per beat, in token order 0..NUM_LOGITS-1.
- Selects the greedy next token: the index of the largest logit.
- Presents the token index and its logit to the token-to-ASCII/output logic through a valid/ready handshake.
- Runs in the ui_clk domain alongside the inference engine.

Parameters:
- NUM_LOGITS, 76, number of logits per packet (vocabulary size).
- TOKEN_W, 7, width of the token index; must satisfy 2^TOKEN_W >= NUM_LOGITS.

Ports:
- clk, input, 1, block clock (ui_clk).
- reset, input, 1, synchronous active-high reset.
- s_logit_valid, input, 1, a logit beat is offered.
- s_logit_ready, output, 1, block accepts a beat this cycle.
- s_logit_data, input, 16, IEEE-754 binary16 logit.
- s_logit_last, input, 1, final beat of the packet.
- m_token_valid, output, 1, result available.
- m_token_ready, input, 1, consumer accepts the result.
- m_token, output, TOKEN_W, argmax token index.
- m_max_logit, output, 16, logit value at m_token (canonicalised).
- m_count_error, output, 1, packet length was not NUM_LOGITS.
- m_all_nan, output, 1, every logit in the packet was NaN.
- busy, output, 1, at least one beat accepted and the result not yet taken.

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values:
  - FSM goes to ACCUM; s_logit_ready = 1.
  - m_token_valid = 0, m_token = 0, m_max_logit = 16'h0000.
  - m_count_error = 0, m_all_nan = 0, busy = 0.
  - Index counter = 0; best_valid = 0.
- Reset mid-packet or while in HOLD discards all partial and held state. No result is emitted.
- FSM states:
  - ACCUM: s_logit_ready = 1, m_token_valid = 0.
  - HOLD: s_logit_ready = 0, m_token_valid = 1. Outputs stay stable until m_token_ready.
- A beat is accepted on s_logit_valid & s_logit_ready. Idle cycles (valid = 0) are allowed anywhere in a packet.
- Per accepted beat, at index idx:
  - NaN (exp = 5'h1F and mantissa != 0): skipped for comparison. idx still increments.
  - -0 (16'h8000) is canonicalised to +0 (16'h0000) before the compare.
  - Compare key: if sign = 1, key = ~x; otherwise key = x ^ 16'h8000. Then unsigned compare. ±inf are ordered normally.
  - If best_valid = 0, or key > best_key (strictly greater), the block replaces best_val/best_idx and sets best_valid = 1.
  - Ties keep the lowest index.
- Packet end is the first of:
  - (a) an accepted beat with s_logit_last = 1;
  - (b) an accepted beat at idx = NUM_LOGITS-1.
- m_count_error = 1 when the packet ended by (a) with idx != NUM_LOGITS-1, or by (b) without last.
- On the packet-end beat, which is included in the compare:
  - The FSM moves to HOLD on the next edge, with m_* registered the same edge.
  - Latency is 1 cycle from the last accepted beat to m_token_valid.
- If no non-NaN beat was seen: m_token = 0, m_max_logit = 16'h7E00, m_all_nan = 1.
- In HOLD, on m_token_ready = 1:
  - Next edge: FSM to ACCUM, m_token_valid = 0, idx = 0, best_valid = 0, flags cleared.
  - s_logit_ready rises one cycle after the output handshake. There is no same-cycle pass-through.
- m_token_ready is ignored in ACCUM.
- busy = (idx != 0) | (state == HOLD).
- No arithmetic beyond the compare and an idx counter of width TOKEN_W. The counter never wraps, because packet end forces a reset to 0.

Test Plan:
- Reset, then stream 76 beats: all 16'h3C00 except idx 41 = 16'h4000 (last on beat 75). Required: exactly 1 cycle later m_token_valid = 1, m_token = 41, m_max_logit = 16'h4000, no flags.
- All 76 beats = 16'hBC00 except idx 10 = 16'hC000 and idx 20 = 16'hBC00. Required: m_token = 0 (first of the ties), m_max_logit = 16'hBC00.
- Mixed special values:
  - idx 0 = 16'h8000, idx 1 = 16'h0000, idx 5 = 16'h7E00 (NaN), idx 6 = 16'h7C00 (+inf), others 16'hC000.
  - Required: m_token = 6, m_max_logit = 16'h7C00.
  - Repeat with idx 6 = 16'hC000. Required: m_token = 0, m_max_logit = 16'h0000.
- Count errors:
  - last asserted on beat 29 (idx 29 max) gives m_token = 29, m_count_error = 1.
  - 76 beats without last end at idx 75 with m_count_error = 1; the next beat starts a new packet.
- Backpressure:
  - Hold m_token_ready = 0 for 10 cycles. Required: outputs stable, s_logit_ready = 0, offered beats not consumed.
  - Then assert m_token_ready. Required: m_token_valid drops next cycle, then s_logit_ready = 1. The following packet's result is independent of the prior one.
- Reset mid-packet:
  - After 30 beats, then after reaching HOLD, assert reset for 1 cycle.
  - Required: m_token_valid = 0, s_logit_ready = 1, busy = 0. A fresh 76-beat packet yields the correct argmax with no stale data.
- All 76 beats NaN (16'h7E00). Required: m_all_nan = 1, m_token = 0, m_max_logit = 16'h7E00.

Source files
------------

// File: rtl/logit_argmax.sv
// Greedy next-token selector: streams FP16 logits for one packet and returns the
// index and canonicalised value of the largest non-NaN logit over a valid/ready port.
module logit_argmax #(
    parameter int NUM_LOGITS = 76,
    parameter int TOKEN_W    = 7
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               s_logit_valid,
    output logic               s_logit_ready,
    input  logic [15:0]        s_logit_data,
    input  logic               s_logit_last,
    output logic               m_token_valid,
    input  logic               m_token_ready,
    output logic [TOKEN_W-1:0] m_token,
    output logic [15:0]        m_max_logit,
    output logic               m_count_error,
    output logic               m_all_nan,
    output logic               busy
);

    // Handshakes: a transfer happens on a rising edge where valid & ready are both high;
    // valid and payload stay stable until that edge, ready may change freely.

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    localparam logic [TOKEN_W-1:0] LAST_IDX = TOKEN_W'(NUM_LOGITS - 1);

    state_t               state_q, state_d;
    logic [TOKEN_W-1:0]   idx_q, idx_d;
    logic                 best_valid_q, best_valid_d;
    logic [15:0]          best_val_q, best_val_d;
    logic [TOKEN_W-1:0]   best_idx_q, best_idx_d;
    logic [TOKEN_W-1:0]   token_q, token_d;
    logic [15:0]          max_logit_q, max_logit_d;
    logic                 count_error_q, count_error_d;
    logic                 all_nan_q, all_nan_d;

    logic                 accept;
    logic                 beat_nan;
    logic [15:0]          beat_canon;
    logic                 take;
    logic                 pkt_end;

    // Maps binary16 onto an unsigned total order (negatives reversed, positives lifted).
    function automatic logic [15:0] sort_key(input logic [15:0] x);
        return x[15] ? ~x : (x ^ 16'h8000);
    endfunction

    always_comb begin
        accept     = s_logit_valid && (state_q == ACCUM);
        beat_nan   = (s_logit_data[14:10] == 5'h1F) && (s_logit_data[9:0] != 10'd0);
        beat_canon = (s_logit_data == 16'h8000) ? 16'h0000 : s_logit_data;
        take       = accept && !beat_nan &&
                     (!best_valid_q || (sort_key(beat_canon) > sort_key(best_val_q)));
        pkt_end    = accept && (s_logit_last || (idx_q == LAST_IDX));

        state_d       = state_q;
        idx_d         = idx_q;
        best_valid_d  = best_valid_q;
        best_val_d    = best_val_q;
        best_idx_d    = best_idx_q;
        token_d       = token_q;
        max_logit_d   = max_logit_q;
        count_error_d = count_error_q;
        all_nan_d     = all_nan_q;

        if (state_q == ACCUM) begin
            if (take) begin
                best_valid_d = 1'b1;
                best_val_d   = beat_canon;
                best_idx_d   = idx_q;
            end
            if (pkt_end) begin
                // The closing beat takes part in the compare, so use the post-take best.
                state_d       = HOLD;
                idx_d         = '0;
                best_valid_d  = 1'b0;
                count_error_d = s_logit_last ? (idx_q != LAST_IDX) : 1'b1;
                if (best_valid_q || take) begin
                    token_d     = take ? idx_q : best_idx_q;
                    max_logit_d = take ? beat_canon : best_val_q;
                    all_nan_d   = 1'b0;
                end else begin
                    token_d     = '0;
                    max_logit_d = 16'h7E00;
                    all_nan_d   = 1'b1;
                end
            end else if (accept) begin
                idx_d = idx_q + 1'b1;
            end
        end else if (m_token_ready) begin
            state_d       = ACCUM;
            count_error_d = 1'b0;
            all_nan_d     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ACCUM;
            idx_q         <= '0;
            best_valid_q  <= 1'b0;
            best_val_q    <= 16'h0000;
            best_idx_q    <= '0;
            token_q       <= '0;
            max_logit_q   <= 16'h0000;
            count_error_q <= 1'b0;
            all_nan_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            best_valid_q  <= best_valid_d;
            best_val_q    <= best_val_d;
            best_idx_q    <= best_idx_d;
            token_q       <= token_d;
            max_logit_q   <= max_logit_d;
            count_error_q <= count_error_d;
            all_nan_q     <= all_nan_d;
        end
    end

    assign s_logit_ready = (state_q == ACCUM);
    assign m_token_valid = (state_q == HOLD);
    assign m_token       = token_q;
    assign m_max_logit   = max_logit_q;
    assign m_count_error = count_error_q;
    assign m_all_nan     = all_nan_q;
    assign busy          = (idx_q != '0) || (state_q == HOLD);

endmodule
